// File: rtl/div_unit_pkg.sv
// div_defs: shared definitions for the multi-cycle divider.
//   DIV_WIDTH       default operand width
//   DIV_* states    2-bit FSM encodings (IDLE, DIVZERO, ON, END)
//   HI_LSB / LO_LSB bit offsets of remainder (HI) and quotient (LO) in result
package div_defs;
    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE    = 2'd0;
    localparam logic [1:0] DIV_DIVZERO = 2'd1;
    localparam logic [1:0] DIV_ON      = 2'd2;
    localparam logic [1:0] DIV_END     = 2'd3;

    localparam int HI_LSB = DIV_WIDTH;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = DIV_IDLE,
        ST_DIVZERO = DIV_DIVZERO,
        ST_ON      = DIV_ON,
        ST_END     = DIV_END
    } div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage <-> divider bundle.
//   master (EX side): drives signed_div, opdata1, opdata2, start, annul;
//                     receives result {rem, quo}, ready, stall_req.
//   slave  (divider): the reverse.
interface div_unit_if #(parameter int WIDTH = div_defs::DIV_WIDTH);
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_req;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready, stall_req
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready, stall_req
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in EX.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - div_unit_if.slave: operands/start/annul in,
//                result {remainder, quotient}, ready, stall_req out
// One quotient bit per cycle; ready rises WIDTH+1 cycles after launch
// (2 cycles for a zero divisor). stall_req = start & ~ready.
// Build option: define DIV_SIGNED_EN to honour signed_div (magnitude
// conversion + sign correction). Without it every divide is unsigned.
module div_unit
    import div_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0]   dq_q, dq_d;       // dividend shifts out the top, quotient in the bottom
    logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               launch;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   fix_rem, fix_quo;

    assign launch = (state_q == ST_IDLE) && bus.start && !bus.annul
                    && (bus.opdata2 != '0);

    // Restoring step. The remainder stays below the divisor, so when the
    // trial difference is negative the shifted value fits in WIDTH bits.
    assign shifted  = {rem_q, dq_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {dq_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    assign a_neg   = bus.signed_div & bus.opdata1[WIDTH-1];
    assign b_neg   = bus.signed_div & bus.opdata2[WIDTH-1];
    assign a_mag   = a_neg ? -bus.opdata1 : bus.opdata1;
    assign b_mag   = b_neg ? -bus.opdata2 : bus.opdata2;
    // Remainder follows the dividend's sign; quotient negates on sign mismatch.
    assign fix_quo = neg_quo_q ? -step_quo : step_quo;
    assign fix_rem = neg_rem_q ? -step_rem : step_rem;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (launch) begin
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = bus.signed_div;
    assign a_mag   = bus.opdata1;
    assign b_mag   = bus.opdata2;
    assign fix_quo = step_quo;
    assign fix_rem = step_rem;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        state_d = ST_DIVZERO;
                    end else begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dq_d    = a_mag;
                        dvs_d   = b_mag;
                    end
                end
            end
            ST_DIVZERO: begin
                if (bus.annul) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d  = ST_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (bus.annul) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end else begin
                    rem_d = step_rem;
                    dq_d  = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = ST_END;
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (bus.annul || !bus.start) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.ready     = ready_q;
    assign bus.stall_req = bus.start & ~ready_q;
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage of the 5-stage MIPS pipeline, serving DIV/DIVU. It is the requesting end of the pipeline stall handshake: it raises a stall request while a division is in flight, and the hazard unit converts that request into F/D/E stalls. On completion it presents the remainder and quotient, which are written to HI and LO respectively.

## Interface
- WIDTH, 32, operand and result width.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled only at launch.
- opdata1  input  WIDTH  dividend; sampled only at launch.
- opdata2  input  WIDTH  divisor; sampled only at launch.
- start  input  1  level request from EX; held high by the pipeline while the DIV is stalled in EX.
- annul  input  1  abort the current operation (flush/exception).
- result  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready  output  1  result is valid.
- stall_req  output  1  combinational: start & ~ready; drives the hazard unit's divide-stall input.

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start=1 and annul=0 and opdata2==0 → DIVZERO.
  - start=1 and annul=0 and opdata2!=0 → ON. Latch |dividend| and |divisor| (magnitudes only when signed_div=1), latch the sign flags, clear the counter.
- ON: one restoring step per cycle.
  - Form the trial difference {partial_rem[WIDTH-1:0], next dividend bit} − divisor.
  - If the difference is non-negative: shift in quotient bit 1 and keep the difference.
  - Otherwise: shift in quotient bit 0 and keep the shifted value.
  - After WIDTH steps (counter reaches WIDTH-1) → END.
  - Apply sign correction as the state is left:
    - Quotient is negated (two's complement) when signed_div=1 and the operand signs differ.
    - Remainder takes the sign of the dividend.
- DIVZERO: result forced to 0 → END.
- END: ready=1 and result is held. Stay in END while start=1; when start=0 → IDLE with ready=0.
- annul=1 in DIVZERO, ON or END → IDLE on the next edge, ready=0, result unchanged. In IDLE, annul blocks a launch.
- Overflow case 0x80000000 / −1 (signed) gives quotient 0x80000000 and remainder 0 (natural wrap). No trap.
- Reset: state=IDLE, counter=0, result=0, ready=0. Reset mid-operation abandons the operation with no output.

## Timing
- Launch edge = cycle 0 (IDLE with start=1). ON occupies cycles 1..WIDTH. END is entered at cycle WIDTH+1, where ready first reads 1.
- stall_req is high from cycle 0 through cycle WIDTH (33 cycles at WIDTH=32). It drops combinationally in the first END cycle, so the DIV advances to MEM on that edge.
- Divide-by-zero: ready=1 at cycle 2. stall_req is high for cycles 0–1.
- Back-to-back DIVs: the second start must be seen in IDLE. The pipeline's one-cycle start drop after END guarantees this.
- Operand changes after launch are ignored.

## Configuration
- DIV_SIGNED_EN
  - Defined: signed_div is honoured, with magnitude conversion and sign correction as above.
  - Undefined: signed_div is ignored, every operation is unsigned, and the negation logic is not built.
  - Timing is identical in both builds.

## Structure
- Shared package div_defs holds:
  - State encoding localparams DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END (2-bit).
  - The default WIDTH.
  - Result field offsets HI_LSB and LO_LSB.
- No sub-module. The trial subtract, counter and FSM stay in div_unit.

## Test plan
- Unsigned 100/7: start held, signed_div=0 → ready at cycle 33; result = {32'd2, 32'd14}; stall_req high exactly 33 cycles.
- Signed −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero 0x1234/0 → ready at cycle 2; result = 0.
- annul asserted at cycle 10 of ON → IDLE next cycle; ready never asserts. A following 9/3 launch yields {0, 3} correctly.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. rst asserted at cycle 5 → ready=0 and result=0 on the next edge.
- END hold: start kept high for 3 cycles after ready → ready and result stable throughout; start drops → IDLE and ready=0 on the next edge.
